// File: rtl/program_sequencer_pkg.sv
// Shared constants and types for the program sequencer: state encoding,
// nibble width and default sizing.
package program_sequencer_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int DEFAULT_WORDS   = 16;
    localparam int DEFAULT_LIMIT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Loader, RAM-write, CPU-control and status signals of the program sequencer.
// Suffixes are seen from the sequencer: _i flows into it, _o flows out of it.
interface program_sequencer_if
    import program_sequencer_pkg::*;
#(
    parameter int LIMIT_W = DEFAULT_LIMIT_W
) ();

    logic               load_start_i;
    logic               abort_i;
    logic               load_valid_i;
    nibble_t            load_data_i;
    logic               load_ready_o;
    logic               ram_we_o;
    nibble_t            ram_addr_o;
    nibble_t            ram_wdata_o;
    logic               cpu_hlt_i;
    logic               cpu_run_o;
    logic [LIMIT_W-1:0] cycle_limit_i;
    state_e             state_o;
    logic               done_o;
    logic               timeout_o;
    logic [LIMIT_W-1:0] cycle_count_o;

    modport master (
        output load_start_i, abort_i, load_valid_i, load_data_i, cpu_hlt_i, cycle_limit_i,
        input  load_ready_o, ram_we_o, ram_addr_o, ram_wdata_o, cpu_run_o,
               state_o, done_o, timeout_o, cycle_count_o
    );

    modport slave (
        input  load_start_i, abort_i, load_valid_i, load_data_i, cpu_hlt_i, cycle_limit_i,
        output load_ready_o, ram_we_o, ram_addr_o, ram_wdata_o, cpu_run_o,
               state_o, done_o, timeout_o, cycle_count_o
    );

endinterface

// File: rtl/program_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable and
// the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/program_sequencer.sv
// Loads a program into the computer RAM over a valid/ready nibble stream,
// then runs the CPU until HLT or until the cycle limit expires.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int WORDS   = DEFAULT_WORDS,
    parameter int LIMIT_W = DEFAULT_LIMIT_W
) (
    input logic               clk,
    input logic               rst,
    program_sequencer_if.slave bus
);

    state_e             state_q;
    logic               load_ready_q;
    logic               ram_we_q;
    nibble_t            ram_addr_q;
    nibble_t            ram_wdata_q;
    nibble_t            index_q;
    logic               cpu_run_q;
    logic               done_q;
    logic               timeout_q;
    logic [LIMIT_W-1:0] cycle_count;

    logic handshake;
    logic last_word;
    logic limit_hit;
    logic start_ok;
    logic cnt_en;
    logic cnt_clr;

    assign handshake = bus.load_valid_i & load_ready_q;
    assign last_word = (index_q == NIBBLE_W'(WORDS - 1));
    assign limit_hit = (bus.cycle_limit_i != '0) &&
                       (cycle_count == bus.cycle_limit_i - LIMIT_W'(1));
    assign start_ok  = bus.load_start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // The exit cycle of RUN still counts, so the final count equals RUN cycles spent.
    assign cnt_en    = (state_q == ST_RUN) && !bus.abort_i;
    assign cnt_clr   = start_ok && !bus.abort_i;

    sat_counter #(.WIDTH(LIMIT_W)) u_cycle_counter (
        .clk     (clk),
        .rst     (rst),
        .en_i    (cnt_en),
        .clr_i   (cnt_clr),
        .count_o (cycle_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            load_ready_q <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            index_q      <= '0;
            cpu_run_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            if (bus.abort_i) begin
                state_q      <= ST_IDLE;
                load_ready_q <= 1'b0;
                index_q      <= '0;
                cpu_run_q    <= 1'b0;
                done_q       <= 1'b0;
                timeout_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start_ok) begin
                            state_q      <= ST_LOAD;
                            load_ready_q <= 1'b1;
                            index_q      <= '0;
                            done_q       <= 1'b0;
                            timeout_q    <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        if (handshake) begin
                            ram_we_q    <= 1'b1;
                            ram_addr_q  <= index_q;
                            ram_wdata_q <= bus.load_data_i;
                            index_q     <= index_q + NIBBLE_W'(1);
                            if (last_word) begin
                                load_ready_q <= 1'b0;
                                state_q      <= ST_RUN;
                                cpu_run_q    <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bus.cpu_hlt_i || limit_hit) begin
                            state_q   <= ST_DONE;
                            cpu_run_q <= 1'b0;
                            done_q    <= 1'b1;
                            timeout_q <= !bus.cpu_hlt_i;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.load_ready_o  = load_ready_q;
    assign bus.ram_we_o      = ram_we_q;
    assign bus.ram_addr_o    = ram_addr_q;
    assign bus.ram_wdata_o   = ram_wdata_q;
    assign bus.cpu_run_o     = cpu_run_q;
    assign bus.state_o       = state_q;
    assign bus.done_o        = done_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.cycle_count_o = cycle_count;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: load, run, halt, timeout, abort,
// asynchronous reset and counter saturation.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    program_sequencer_if #(.LIMIT_W(8)) bus ();

    program_sequencer #(.WORDS(16), .LIMIT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a load and streams 16 nibbles back-to-back: (15-i) ^ seed at word i.
    task automatic load_b2b(input logic [3:0] seed);
        bus.load_start_i = 1'b1;
        step();
        bus.load_start_i = 1'b0;
        check("enter_load",  32'(bus.state_o), 32'(ST_LOAD));
        check("ready_up",    32'(bus.load_ready_o), 32'd1);
        check("count_clr",   32'(bus.cycle_count_o), 32'd0);
        check("done_clr",    32'(bus.done_o), 32'd0);
        for (int i = 0; i < 16; i++) begin
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = 4'(15 - i) ^ seed;
            step();
            check("b2b_we",    32'(bus.ram_we_o), 32'd1);
            check("b2b_addr",  32'(bus.ram_addr_o), 32'(i));
            check("b2b_data",  32'(bus.ram_wdata_o), 32'(4'(15 - i) ^ seed));
            check("b2b_ready", 32'(bus.load_ready_o), (i == 15) ? 32'd0 : 32'd1);
            check("b2b_state", 32'(bus.state_o), (i == 15) ? 32'(ST_RUN) : 32'(ST_LOAD));
        end
        check("run_on", 32'(bus.cpu_run_o), 32'd1);
        bus.load_valid_i = 1'b0;
        bus.load_data_i  = 4'h0;
    endtask

    initial begin
        bus.load_start_i  = 1'b0;
        bus.abort_i       = 1'b0;
        bus.load_valid_i  = 1'b0;
        bus.load_data_i   = 4'h0;
        bus.cpu_hlt_i     = 1'b0;
        bus.cycle_limit_i = 8'd0;

        // Reset state
        #2;
        check("rst_state", 32'(bus.state_o), 32'(ST_IDLE));
        check("rst_ready", 32'(bus.load_ready_o), 32'd0);
        check("rst_we",    32'(bus.ram_we_o), 32'd0);
        check("rst_run",   32'(bus.cpu_run_o), 32'd0);
        check("rst_count", 32'(bus.cycle_count_o), 32'd0);
        step();
        step();
        rst = 1'b0;

        // IDLE ignores cpu_hlt and load_valid
        bus.cpu_hlt_i    = 1'b1;
        bus.load_valid_i = 1'b1;
        step();
        check("idle_hlt_state", 32'(bus.state_o), 32'(ST_IDLE));
        check("idle_no_we",     32'(bus.ram_we_o), 32'd0);
        bus.cpu_hlt_i    = 1'b0;
        bus.load_valid_i = 1'b0;

        // Back-to-back load F..0, unlimited run, HLT on RUN cycle 5
        load_b2b(4'h0);
        step();
        check("run1_no_we", 32'(bus.ram_we_o), 32'd0);
        check("run1_count", 32'(bus.cycle_count_o), 32'd1);
        step();
        step();
        step();
        check("run5_count", 32'(bus.cycle_count_o), 32'd4);
        bus.cpu_hlt_i = 1'b1;
        step();
        bus.cpu_hlt_i = 1'b0;
        check("hlt_state",   32'(bus.state_o), 32'(ST_DONE));
        check("hlt_done",    32'(bus.done_o), 32'd1);
        check("hlt_timeout", 32'(bus.timeout_o), 32'd0);
        check("hlt_count",   32'(bus.cycle_count_o), 32'd5);
        check("hlt_run_off", 32'(bus.cpu_run_o), 32'd0);
        step();
        check("done_hold_count", 32'(bus.cycle_count_o), 32'd5);
        check("done_hold_done",  32'(bus.done_o), 32'd1);

        // Toggling load_valid, then timeout at limit 10
        bus.cycle_limit_i = 8'd10;
        bus.load_start_i  = 1'b1;
        step();
        bus.load_start_i = 1'b0;
        check("tog_enter", 32'(bus.state_o), 32'(ST_LOAD));
        for (int k = 0; k < 16; k++) begin
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = 4'(k);
            step();
            check("tog_we",   32'(bus.ram_we_o), 32'd1);
            check("tog_addr", 32'(bus.ram_addr_o), 32'(k));
            check("tog_data", 32'(bus.ram_wdata_o), 32'(k));
            if (k != 15) begin
                bus.load_valid_i = 1'b0;
                step();
                check("tog_gap_no_we", 32'(bus.ram_we_o), 32'd0);
            end
        end
        bus.load_valid_i = 1'b0;
        check("tog_run", 32'(bus.state_o), 32'(ST_RUN));
        for (int c = 0; c < 9; c++) step();
        check("to_cycle10_state", 32'(bus.state_o), 32'(ST_RUN));
        check("to_cycle10_count", 32'(bus.cycle_count_o), 32'd9);
        step();
        check("to_state",   32'(bus.state_o), 32'(ST_DONE));
        check("to_done",    32'(bus.done_o), 32'd1);
        check("to_timeout", 32'(bus.timeout_o), 32'd1);
        check("to_count",   32'(bus.cycle_count_o), 32'd10);

        // HLT coinciding with limit expiry: HLT wins
        load_b2b(4'h5);
        for (int c = 0; c < 9; c++) step();
        bus.cpu_hlt_i = 1'b1;
        step();
        bus.cpu_hlt_i = 1'b0;
        check("tie_state",   32'(bus.state_o), 32'(ST_DONE));
        check("tie_timeout", 32'(bus.timeout_o), 32'd0);
        check("tie_count",   32'(bus.cycle_count_o), 32'd10);

        // Abort at word 7, then restart from address 0
        bus.cycle_limit_i = 8'd0;
        bus.load_start_i  = 1'b1;
        step();
        bus.load_start_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = 4'(i);
            step();
        end
        check("pre_abort_addr", 32'(bus.ram_addr_o), 32'd6);
        bus.load_data_i = 4'h7;
        bus.abort_i     = 1'b1;
        step();
        bus.abort_i = 1'b0;
        check("abort_state", 32'(bus.state_o), 32'(ST_IDLE));
        check("abort_ready", 32'(bus.load_ready_o), 32'd0);
        check("abort_no_we", 32'(bus.ram_we_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_abort_no_we", 32'(bus.ram_we_o), 32'd0);
        end
        bus.load_valid_i = 1'b0;
        load_b2b(4'hA);

        // Asynchronous reset mid-RUN clears everything before the next edge
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_state",   32'(bus.state_o), 32'(ST_IDLE));
        check("arst_run",     32'(bus.cpu_run_o), 32'd0);
        check("arst_count",   32'(bus.cycle_count_o), 32'd0);
        check("arst_addr",    32'(bus.ram_addr_o), 32'd0);
        check("arst_wdata",   32'(bus.ram_wdata_o), 32'd0);
        check("arst_we",      32'(bus.ram_we_o), 32'd0);
        check("arst_ready",   32'(bus.load_ready_o), 32'd0);
        check("arst_done",    32'(bus.done_o), 32'd0);
        check("arst_timeout", 32'(bus.timeout_o), 32'd0);
        step();
        rst = 1'b0;

        // Unlimited 300-cycle run saturates the counter at 255
        load_b2b(4'h3);
        for (int c = 0; c < 300; c++) step();
        check("sat_state", 32'(bus.state_o), 32'(ST_RUN));
        check("sat_count", 32'(bus.cycle_count_o), 32'd255);
        bus.load_start_i = 1'b1;
        step();
        bus.load_start_i = 1'b0;
        check("run_ignores_start", 32'(bus.state_o), 32'(ST_RUN));
        bus.cpu_hlt_i = 1'b1;
        step();
        bus.cpu_hlt_i = 1'b0;
        check("sat_done_state", 32'(bus.state_o), 32'(ST_DONE));
        check("sat_done_count", 32'(bus.cycle_count_o), 32'd255);
        check("sat_timeout",    32'(bus.timeout_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter: WORDS, default 16, number of 4-bit words loaded into computer RAM per program (addresses 0..WORDS-1).
REQ-002 Parameter: LIMIT_W, default 8, width of cycle limit and cycle counter.
REQ-003 clock  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  single-cycle request to begin loading a program.
REQ-006 abort  input  1  forces return to IDLE from any state.
REQ-007 load_valid  input  1  load_data holds a valid nibble.
REQ-008 load_data  input  4  program/data nibble.
REQ-009 load_ready  output  1  sequencer accepts a nibble this cycle.
REQ-010 ram_we  output  1  one-cycle write strobe to computer RAM.
REQ-011 ram_addr  output  4  RAM write address.
REQ-012 ram_wdata  output  4  RAM write data.
REQ-013 cpu_hlt  input  1  HLT flag from the computer.
REQ-014 cpu_run  output  1  enables computer execution; low holds it stalled.
REQ-015 cycle_limit  input  LIMIT_W  maximum RUN cycles; 0 = unlimited.
REQ-016 state  output  2  current FSM state encoding.
REQ-017 done  output  1  program finished (halt or timeout).
REQ-018 timeout  output  1  run ended by cycle_limit, not HLT.
REQ-019 cycle_count  output  LIMIT_W  cycles spent in RUN, saturating.

Function
REQ-020 FSM states SHALL be IDLE=0, LOAD=1, RUN=2, DONE=3.
REQ-021 Priority each cycle SHALL be reset > abort > normal transitions; abort forces IDLE next cycle, clears cpu_run, load_ready, ram_we, done, timeout, word index.
REQ-022 IDLE: load_ready=0, cpu_run=0; load_start=1 -> LOAD next cycle, word index=0, cycle_count=0.
REQ-023 LOAD: load_ready=1 while word index < WORDS; handshake = load_valid & load_ready.
REQ-024 On a handshake, the cycle after SHALL show ram_we=1, ram_addr=index, ram_wdata=load_data (registered, 1-cycle latency); ram_we SHALL be 0 in all other cycles.
REQ-025 Index increments by 1 per handshake; load_valid without load_ready SHALL be ignored; gaps in load_valid are permitted.
REQ-026 Handshake on word WORDS-1: load_ready SHALL be 0 from the next cycle; FSM enters RUN the same cycle the final ram_we pulse is asserted.
REQ-027 load_start in LOAD or RUN SHALL be ignored.
REQ-028 RUN: cpu_run=1; cycle_count increments by 1 each RUN cycle, saturating at 2^LIMIT_W-1 (no wrap).
REQ-029 RUN, cpu_hlt=1 sampled -> DONE next cycle, done=1, timeout=0, cpu_run=0.
REQ-030 RUN, cycle_limit!=0 and cycle_count==cycle_limit-1 with cpu_hlt=0 -> DONE, done=1, timeout=1.
REQ-031 Simultaneous cpu_hlt and limit expiry: HLT wins, timeout=0.
REQ-032 DONE: done, timeout, cycle_count held; cpu_run=0; load_start -> LOAD with done, timeout, cycle_count, index cleared.
REQ-033 cpu_hlt outside RUN SHALL be ignored.

Reset
REQ-034 On reset assertion, immediately: state=IDLE, load_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_run=0, done=0, timeout=0, cycle_count=0, index=0.
REQ-035 Reset mid-LOAD or mid-RUN SHALL abandon the operation with no further ram_we pulse.

Structure
REQ-036 Shared package holds state encoding constants, default WORDS, LIMIT_W and nibble width 4.
REQ-037 One sub-module, sat_counter (enable, clear, saturating LIMIT_W-bit count), SHALL implement cycle_count.

Verification
REQ-038 Load 16 nibbles 0xF..0x0 back-to-back -> ram_we pulses addr 0..15 with data F..0, each one cycle after its handshake; RUN entered after 16th.
REQ-039 Load with load_valid toggling every other cycle -> exactly 16 writes, no duplicates, addresses contiguous.
REQ-040 RUN, cycle_limit=0, cpu_hlt raised on RUN cycle 5 -> DONE, done=1, timeout=0, cycle_count=5.
REQ-041 RUN, cycle_limit=10, cpu_hlt=0 -> DONE after 10 RUN cycles, timeout=1, cycle_count=10; repeat with cpu_hlt rising on cycle 10 -> timeout=0.
REQ-042 Abort at word 7 of LOAD -> IDLE next cycle, no ram_we afterward; new load_start restarts at addr 0.
REQ-043 Reset asserted asynchronously mid-RUN -> all outputs zero before next clock edge; cycle_limit=0 run of 300 cycles -> cycle_count saturates at 255.
